// File: rtl/word_serializer_5bit.sv
// -----------------------------------------------------------------------------
// word_serializer_5bit
//
// Parallel-in / serial-out transmit stage. It accepts a WIDTH-bit word through
// a valid/ready handshake and shifts it out LSB-first, one bit per clock.
// Bit 0 goes out first, so a downstream right-shifting SIPO register (new bit
// entering at the MSB) holds the accepted word in its natural bit order
// WIDTH clocks after acceptance. o_word_done marks that cycle. Back-to-back
// words stream without gap cycles.
//
// Parameters
//   WIDTH       word length; must match the downstream shift register depth
//   IDLE_LEVEL  level driven on o_serial_out while no word is in flight
//
// Ports
//   i_clk         clock; all state updates on the rising edge
//   i_reset       asynchronous, active-high reset
//   i_data_in     word to transmit; sampled only on an accept edge
//   i_load        valid: i_data_in holds a word to send
//   o_ready       a word can be accepted at the next rising edge
//   o_serial_out  registered serial bit, drives the downstream serial input
//   o_busy        a word is being shifted out
//   o_word_done   one-cycle strobe: downstream now holds the last word in full
// -----------------------------------------------------------------------------
module word_serializer_5bit #(
   parameter int   WIDTH      = 5,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_data_in,
   input  logic             i_load,
   output logic             o_ready,
   output logic             o_serial_out,
   output logic             o_busy,
   output logic             o_word_done
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_serial;
   logic             w_serial_next;
   logic             r_word_done;
   logic             w_word_done_next;

   logic             w_last;
   logic             w_accept;

   // The last bit of a word is on the line: the downstream register captures
   // it at the coming edge, and a new word may be accepted at that same edge.
   assign w_last   = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
   // ready depends on state/cnt only, never on i_load.
   assign o_ready  = (r_state == ST_IDLE) || w_last;
   assign w_accept = i_load && o_ready;

   always_comb begin
      w_state_next     = r_state;
      w_shreg_next     = r_shreg;
      w_cnt_next       = r_cnt;
      w_serial_next    = r_serial;
      w_word_done_next = w_last;

      if (w_accept) begin
         // Bit 0 goes straight to the line; the rest wait in the shifter.
         w_serial_next = i_data_in[0];
         w_shreg_next  = i_data_in >> 1;
         w_cnt_next    = '0;
         w_state_next  = ST_SHIFT;
      end else begin
         case (r_state)
            ST_SHIFT: begin
               if (w_last) begin
                  w_state_next  = ST_IDLE;
                  w_serial_next = IDLE_LEVEL;
                  w_cnt_next    = '0;
               end else begin
                  w_serial_next = r_shreg[0];
                  w_shreg_next  = r_shreg >> 1;
                  w_cnt_next    = r_cnt + CNT_ONE;
               end
            end
            ST_IDLE: begin
               w_serial_next = IDLE_LEVEL;
               w_cnt_next    = '0;
            end
            default: begin
               w_state_next  = ST_IDLE;
               w_serial_next = IDLE_LEVEL;
               w_cnt_next    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_serial    <= IDLE_LEVEL;
         r_word_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_shreg     <= w_shreg_next;
         r_cnt       <= w_cnt_next;
         r_serial    <= w_serial_next;
         r_word_done <= w_word_done_next;
      end
   end

   assign o_serial_out = r_serial;
   assign o_busy       = (r_state == ST_SHIFT);
   assign o_word_done  = r_word_done;

endmodule

// File: tb/tb_word_serializer_5bit.sv
// -----------------------------------------------------------------------------
// tb_word_serializer_5bit
//
// Self-checking bench for word_serializer_5bit. Two instances share clock and
// reset: dut0 with the default idle level 0 and dut1 with idle level 1. Each
// feeds a model of the downstream 5-bit SIPO register. Expected serial bits and
// words are pushed to queues when a word is driven and popped as the DUT
// produces them. Inputs change on the falling edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_word_serializer_5bit;

   logic       clk;
   logic       reset;
   logic [4:0] data0, data1;
   logic       load0, load1;
   logic       ready0, serial0, busy0, done0;
   logic       ready1, serial1, busy1, done1;
   logic [4:0] down0, down1;

   int         n_checks;
   int         n_fail;
   logic       q_bits[$];
   logic [4:0] q_words[$];
   logic       exp_bit;
   logic [4:0] exp_word;

   word_serializer_5bit #(.WIDTH(5), .IDLE_LEVEL(1'b0)) dut0 (
      .i_clk(clk), .i_reset(reset), .i_data_in(data0), .i_load(load0),
      .o_ready(ready0), .o_serial_out(serial0), .o_busy(busy0), .o_word_done(done0)
   );

   word_serializer_5bit #(.WIDTH(5), .IDLE_LEVEL(1'b1)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_data_in(data1), .i_load(load1),
      .o_ready(ready1), .o_serial_out(serial1), .o_busy(busy1), .o_word_done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream SIPO registers: new bit enters at the MSB, shifts right.
   always @(posedge clk) begin
      down0 <= {serial0, down0[4:1]};
      down1 <= {serial1, down1[4:1]};
   end

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_word(input logic [4:0] w);
      for (int b = 0; b < 5; b++) q_bits.push_back(w[b]);
      q_words.push_back(w);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step();
      n_checks++; if (serial0 !== 1'b0) begin n_fail++; $display("FAIL reset_serial0: got %b want 0", serial0); end
      n_checks++; if (serial1 !== 1'b1) begin n_fail++; $display("FAIL reset_serial1: got %b want 1", serial1); end
      n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
      n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready0); end
      n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
      reset = 1'b0;
      step();
      n_checks++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: ready=%b busy=%b want 1/0", ready0, busy0); end
      $display("test_reset done");
   endtask

   task automatic test_single(input logic [4:0] w);
      data0 = w; load0 = 1'b1; push_word(w);
      for (int k = 0; k < 5; k++) begin
         step();
         load0 = 1'b0;
         exp_bit = q_bits.pop_front();
         n_checks++; if (serial0 !== exp_bit) begin n_fail++; $display("FAIL single_bit%0d: got %b want %b", k, serial0, exp_bit); end
         n_checks++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin n_fail++; $display("FAIL single_busy%0d: busy=%b done=%b want 1/0", k, busy0, done0); end
         n_checks++; if (ready0 !== (k == 4)) begin n_fail++; $display("FAIL single_ready%0d: got %b want %b", k, ready0, (k == 4)); end
      end
      step();
      exp_word = q_words.pop_front();
      n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done0); end
      n_checks++; if (down0 !== exp_word) begin n_fail++; $display("FAIL single_down: got %b want %b", down0, exp_word); end
      n_checks++; if (serial0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL single_idle: serial=%b busy=%b want 0/0", serial0, busy0); end
      step();
      n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", done0); end
      $display("test_single word=%b done", w);
   endtask

   task automatic test_back_to_back;
      logic [4:0] w [3];
      w[0] = 5'b00001; w[1] = 5'b11110; w[2] = 5'b01101;
      data0 = w[0]; load0 = 1'b1; push_word(w[0]);
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 5; k++) begin
            step();
            load0 = 1'b0;
            n_checks++; if (done0 !== (k == 0 && i > 0)) begin n_fail++; $display("FAIL b2b_done w%0d k%0d: got %b want %b", i, k, done0, (k == 0 && i > 0)); end
            if (k == 0 && i > 0) begin
               exp_word = q_words.pop_front();
               n_checks++; if (down0 !== exp_word) begin n_fail++; $display("FAIL b2b_down w%0d: got %b want %b", i - 1, down0, exp_word); end
            end
            exp_bit = q_bits.pop_front();
            n_checks++; if (serial0 !== exp_bit || busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_bit w%0d k%0d: serial=%b busy=%b want %b/1", i, k, serial0, busy0, exp_bit); end
            if (k == 4 && i < 2) begin
               data0 = w[i+1]; load0 = 1'b1; push_word(w[i+1]);
            end
         end
      end
      step();
      exp_word = q_words.pop_front();
      n_checks++; if (done0 !== 1'b1 || down0 !== exp_word) begin n_fail++; $display("FAIL b2b_last: done=%b down=%b want 1/%b", done0, down0, exp_word); end
      step();
      n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_end: done=%b busy=%b want 0/0", done0, busy0); end
      $display("test_back_to_back done");
   endtask

   task automatic test_load_busy;
      data0 = 5'b11001; load0 = 1'b1; push_word(5'b11001);
      for (int k = 0; k < 5; k++) begin
         step();
         // Hold a competing word on the input during cycles t+2..t+4.
         load0 = (k >= 1 && k <= 3);
         if (k >= 1) data0 = 5'b01010;
         exp_bit = q_bits.pop_front();
         n_checks++; if (serial0 !== exp_bit) begin n_fail++; $display("FAIL lb_bit%0d: got %b want %b", k, serial0, exp_bit); end
         n_checks++; if (ready0 !== (k == 4)) begin n_fail++; $display("FAIL lb_ready%0d: got %b want %b", k, ready0, (k == 4)); end
      end
      step();
      exp_word = q_words.pop_front();
      n_checks++; if (done0 !== 1'b1 || down0 !== exp_word) begin n_fail++; $display("FAIL lb_done: done=%b down=%b want 1/%b", done0, down0, exp_word); end
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL lb_extra%0d: done=%b busy=%b want 0/0", k, done0, busy0); end
      end
      $display("test_load_busy done");
   endtask

   task automatic test_data_change;
      data0 = 5'b11111; load0 = 1'b1; push_word(5'b11111);
      for (int k = 0; k < 5; k++) begin
         step();
         load0 = 1'b0; data0 = 5'b00000;
         exp_bit = q_bits.pop_front();
         n_checks++; if (serial0 !== exp_bit) begin n_fail++; $display("FAIL dc_bit%0d: got %b want %b", k, serial0, exp_bit); end
      end
      step();
      exp_word = q_words.pop_front();
      n_checks++; if (done0 !== 1'b1 || down0 !== exp_word) begin n_fail++; $display("FAIL dc_done: done=%b down=%b want 1/%b", done0, down0, exp_word); end
      step();
      $display("test_data_change done");
   endtask

   task automatic test_reset_mid;
      data0 = 5'b10101; load0 = 1'b1; push_word(5'b10101);
      for (int k = 0; k < 3; k++) begin
         step();
         load0 = 1'b0;
         exp_bit = q_bits.pop_front();
         n_checks++; if (serial0 !== exp_bit) begin n_fail++; $display("FAIL rm_bit%0d: got %b want %b", k, serial0, exp_bit); end
      end
      // Abort in cycle t+3, between clock edges.
      #2 reset = 1'b1;
      #1;
      n_checks++; if (serial0 !== 1'b0 || busy0 !== 1'b0 || ready0 !== 1'b1) begin n_fail++; $display("FAIL rm_async: serial=%b busy=%b ready=%b want 0/0/1", serial0, busy0, ready0); end
      q_bits.delete();
      q_words.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL rm_no_done%0d: done=%b busy=%b want 0/0", k, done0, busy0); end
         step();
      end
      data0 = 5'b00111; load0 = 1'b1; push_word(5'b00111);
      for (int k = 0; k < 5; k++) begin
         step();
         load0 = 1'b0;
         exp_bit = q_bits.pop_front();
         n_checks++; if (serial0 !== exp_bit) begin n_fail++; $display("FAIL rm_new_bit%0d: got %b want %b", k, serial0, exp_bit); end
      end
      step();
      exp_word = q_words.pop_front();
      n_checks++; if (done0 !== 1'b1 || down0 !== exp_word) begin n_fail++; $display("FAIL rm_new_done: done=%b down=%b want 1/%b", done0, down0, exp_word); end
      step();
      $display("test_reset_mid done");
   endtask

   task automatic test_idle_level1;
      n_checks++; if (serial1 !== 1'b1) begin n_fail++; $display("FAIL il_idle_before: got %b want 1", serial1); end
      data1 = 5'b00000; load1 = 1'b1; push_word(5'b00000);
      for (int k = 0; k < 5; k++) begin
         step();
         load1 = 1'b0;
         exp_bit = q_bits.pop_front();
         n_checks++; if (serial1 !== exp_bit || busy1 !== 1'b1) begin n_fail++; $display("FAIL il_bit%0d: serial=%b busy=%b want %b/1", k, serial1, busy1, exp_bit); end
      end
      step();
      exp_word = q_words.pop_front();
      n_checks++; if (done1 !== 1'b1 || down1 !== exp_word) begin n_fail++; $display("FAIL il_done: done=%b down=%b want 1/%b", done1, down1, exp_word); end
      n_checks++; if (serial1 !== 1'b1 || ready1 !== 1'b1) begin n_fail++; $display("FAIL il_idle_after: serial=%b ready=%b want 1/1", serial1, ready1); end
      step();
      n_checks++; if (serial1 !== 1'b1 || done1 !== 1'b0) begin n_fail++; $display("FAIL il_idle_hold: serial=%b done=%b want 1/0", serial1, done1); end
      $display("test_idle_level1 done");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      data0    = '0;
      data1    = '0;
      load0    = 1'b0;
      load1    = 1'b0;
      @(negedge clk);
      test_reset();
      test_single(5'b10110);
      test_back_to_back();
      test_load_busy();
      test_data_change();
      test_reset_mid();
      test_idle_level1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
